// File: rtl/display_update_scheduler.sv
// rtl/display_update_scheduler.sv - frame-synchronous commit of rover location/orientation to the VGA writer
module display_update_scheduler #(
  parameter int STALE_FRAMES    = 120,
  parameter int FRAME_CNT_WIDTH = 16
) (
  input  logic                       vclock,
  input  logic                       reset,
  input  logic                       vsync,
  input  logic [11:0]                loc_in,
  input  logic                       loc_valid,
  input  logic [4:0]                 orient_in,
  input  logic                       orient_valid,
  output logic [11:0]                location,
  output logic [4:0]                 orientation,
  output logic                       new_data,
  output logic                       orientation_ready,
  output logic                       stale,
  output logic [7:0]                 dropped_count,
  output logic [FRAME_CNT_WIDTH-1:0] frame_count
);

  localparam int SW = $clog2(STALE_FRAMES + 1);
  localparam logic [SW-1:0] STALE_MAX = SW'(STALE_FRAMES);

  typedef enum logic [1:0] {ACTIVE, COMMIT, HOLD} state_t;

  state_t        state;
  logic          vsync_q;
  logic [11:0]   loc_buf;
  logic          loc_pend;
  logic [4:0]    orient_buf;
  logic          orient_pend;
  logic [SW-1:0] stale_cnt;

  logic          frame_start;
  logic          commit;
  logic [SW-1:0] stale_cnt_inc;
  logic          stale_after;
  logic          loc_drop;
  logic          orient_drop;
  logic [8:0]    drop_sum;
  logic [7:0]    drop_next;

  always_comb begin
    frame_start   = vsync_q & ~vsync;
    commit        = (state == COMMIT);
    stale_cnt_inc = (stale_cnt == STALE_MAX) ? stale_cnt : stale_cnt + 1'b1;
    // Staleness as it will stand once this commit cycle's location update lands
    stale_after   = !loc_pend && (stale_cnt_inc == STALE_MAX);
    loc_drop      = loc_valid && loc_pend && !commit;
    orient_drop   = orient_valid && orient_pend && !commit;
    drop_sum      = {1'b0, dropped_count} + {8'd0, loc_drop} + {8'd0, orient_drop};
    drop_next     = drop_sum[8] ? 8'hff : drop_sum[7:0];
  end

  always_ff @(posedge vclock) begin
    if (reset) begin
      state             <= ACTIVE;
      vsync_q           <= 1'b1;
      loc_buf           <= '0;
      loc_pend          <= 1'b0;
      orient_buf        <= '0;
      orient_pend       <= 1'b0;
      stale_cnt         <= STALE_MAX;
      location          <= '0;
      orientation       <= '0;
      new_data          <= 1'b0;
      orientation_ready <= 1'b0;
      stale             <= 1'b1;
      dropped_count     <= '0;
      frame_count       <= '0;
    end else begin
      vsync_q       <= vsync;
      dropped_count <= drop_next;
      if (frame_start)
        frame_count <= frame_count + 1'b1;

      // A strobe in the commit cycle re-arms the pending flag for the next frame
      if (loc_valid) begin
        loc_buf  <= loc_in;
        loc_pend <= 1'b1;
      end else if (commit) begin
        loc_pend <= 1'b0;
      end
      if (orient_valid) begin
        orient_buf  <= orient_in;
        orient_pend <= 1'b1;
      end else if (commit) begin
        orient_pend <= 1'b0;
      end

      case (state)
        ACTIVE: begin
          new_data <= 1'b0;
          if (frame_start)
            state <= COMMIT;
        end
        COMMIT: begin
          state <= HOLD;
          if (loc_pend) begin
            location  <= loc_buf;
            new_data  <= 1'b1;
            stale_cnt <= '0;
            stale     <= 1'b0;
            if (!orient_pend)
              orientation_ready <= 1'b0;
          end else begin
            stale_cnt <= stale_cnt_inc;
            if (stale_after) begin
              stale             <= 1'b1;
              orientation_ready <= 1'b0;
            end
          end
          if (orient_pend && !stale_after) begin
            orientation       <= orient_buf;
            orientation_ready <= 1'b1;
          end
        end
        HOLD: begin
          if (vsync)
            state <= ACTIVE;
        end
        default: state <= ACTIVE;
      endcase
    end
  end

endmodule

// File: tb/tb_display_update_scheduler.sv
// tb/tb_display_update_scheduler.sv - directed self-checking bench for display_update_scheduler
module tb_display_update_scheduler;

  logic        vclock = 1'b0;
  logic        reset;
  logic        vsync;
  logic [11:0] loc_in;
  logic        loc_valid;
  logic [4:0]  orient_in;
  logic        orient_valid;
  logic [11:0] location;
  logic [4:0]  orientation;
  logic        new_data;
  logic        orientation_ready;
  logic        stale;
  logic [7:0]  dropped_count;
  logic [15:0] frame_count;

  int n_checks = 0;
  int n_fail   = 0;
  logic nd_commit;

  display_update_scheduler #(.STALE_FRAMES(4), .FRAME_CNT_WIDTH(16)) dut (
    .vclock(vclock), .reset(reset), .vsync(vsync),
    .loc_in(loc_in), .loc_valid(loc_valid),
    .orient_in(orient_in), .orient_valid(orient_valid),
    .location(location), .orientation(orientation), .new_data(new_data),
    .orientation_ready(orientation_ready), .stale(stale),
    .dropped_count(dropped_count), .frame_count(frame_count)
  );

  always #5 vclock = ~vclock;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(negedge vclock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic loc_strobe(input logic [11:0] v);
    loc_in = v; loc_valid = 1'b1; tick; loc_valid = 1'b0;
  endtask

  task automatic orient_strobe(input logic [4:0] v);
    orient_in = v; orient_valid = 1'b1; tick; orient_valid = 1'b0;
  endtask

  task automatic vsync_fall;
    vsync = 1'b0; tick;
  endtask

  // First tick lands on the commit edge; new_data is captured right after it
  task automatic finish_frame;
    tick;
    loc_valid = 1'b0; orient_valid = 1'b0;
    nd_commit = new_data;
    repeat (3) tick;
    vsync = 1'b1;
    repeat (4) tick;
  endtask

  task automatic frame;
    vsync_fall;
    finish_frame;
  endtask

  initial begin
    reset = 1'b1; vsync = 1'b1; loc_in = '0; loc_valid = 1'b0;
    orient_in = '0; orient_valid = 1'b0;
    tick; tick;
    reset = 1'b0;
    tick;
    chk("rst_location", 32'(location), 32'h0);
    chk("rst_orientation", 32'(orientation), 32'h0);
    chk("rst_new_data", 32'(new_data), 32'h0);
    chk("rst_ready", 32'(orientation_ready), 32'h0);
    chk("rst_stale", 32'(stale), 32'h1);
    chk("rst_dropped", 32'(dropped_count), 32'h0);
    chk("rst_frame", 32'(frame_count), 32'h0);

    // Single location, detailed new_data timing
    repeat (3) tick;
    loc_strobe(12'h345);
    tick;
    vsync = 1'b0;
    tick;
    chk("t1_nd_fall+1", 32'(new_data), 32'h0);
    tick;
    chk("t1_nd_fall+2", 32'(new_data), 32'h1);
    chk("t1_location", 32'(location), 32'h345);
    chk("t1_stale", 32'(stale), 32'h0);
    chk("t1_frame", 32'(frame_count), 32'h1);
    repeat (2) tick;
    chk("t1_nd_hold", 32'(new_data), 32'h1);
    vsync = 1'b1;
    tick;
    chk("t1_nd_rise+1", 32'(new_data), 32'h1);
    tick;
    chk("t1_nd_rise+2", 32'(new_data), 32'h0);
    chk("t1_loc_stable", 32'(location), 32'h345);
    tick; tick;

    // Overwrites: last wins, two drops
    loc_strobe(12'h001);
    loc_strobe(12'h002);
    loc_strobe(12'h003);
    frame;
    chk("t2_location", 32'(location), 32'h003);
    chk("t2_dropped", 32'(dropped_count), 32'h2);
    chk("t2_nd", 32'(nd_commit), 32'h1);
    chk("t2_frame", 32'(frame_count), 32'h2);

    // Location + orientation, then location only
    loc_strobe(12'h010);
    orient_strobe(5'd7);
    frame;
    chk("t3_orientation", 32'(orientation), 32'h7);
    chk("t3_ready", 32'(orientation_ready), 32'h1);
    chk("t3_dropped", 32'(dropped_count), 32'h2);
    loc_strobe(12'h020);
    frame;
    chk("t3b_location", 32'(location), 32'h020);
    chk("t3b_ready", 32'(orientation_ready), 32'h0);
    chk("t3b_orientation", 32'(orientation), 32'h7);

    // Staleness after 4 empty frames
    loc_strobe(12'h030);
    orient_strobe(5'd9);
    frame;
    chk("t4_ready_init", 32'(orientation_ready), 32'h1);
    chk("t4_orient_init", 32'(orientation), 32'h9);
    frame; frame; frame;
    chk("t4_stale_3", 32'(stale), 32'h0);
    chk("t4_ready_3", 32'(orientation_ready), 32'h1);
    chk("t4_nd_empty", 32'(nd_commit), 32'h0);
    frame;
    chk("t4_stale_4", 32'(stale), 32'h1);
    chk("t4_ready_4", 32'(orientation_ready), 32'h0);
    orient_strobe(5'd5);
    frame;
    chk("t4_ready_disc", 32'(orientation_ready), 32'h0);
    chk("t4_orient_disc", 32'(orientation), 32'h9);
    chk("t4_frame", 32'(frame_count), 32'd10);

    // Strobe exactly in the commit cycle
    vsync_fall;
    loc_in = 12'h055; loc_valid = 1'b1;
    finish_frame;
    chk("t5_nd_none", 32'(nd_commit), 32'h0);
    chk("t5_loc_kept", 32'(location), 32'h030);
    frame;
    chk("t5_nd_next", 32'(nd_commit), 32'h1);
    chk("t5_location", 32'(location), 32'h055);
    chk("t5_stale", 32'(stale), 32'h0);
    chk("t5_dropped", 32'(dropped_count), 32'h2);
    chk("t5_frame", 32'(frame_count), 32'd12);

    // Reset during HOLD with a pending update
    loc_strobe(12'h066);
    orient_strobe(5'd3);
    vsync_fall;
    tick;
    chk("t6_location", 32'(location), 32'h066);
    chk("t6_ready", 32'(orientation_ready), 32'h1);
    loc_strobe(12'h077);
    reset = 1'b1;
    tick;
    chk("t6_rst_location", 32'(location), 32'h0);
    chk("t6_rst_orientation", 32'(orientation), 32'h0);
    chk("t6_rst_nd", 32'(new_data), 32'h0);
    chk("t6_rst_ready", 32'(orientation_ready), 32'h0);
    chk("t6_rst_stale", 32'(stale), 32'h1);
    chk("t6_rst_dropped", 32'(dropped_count), 32'h0);
    chk("t6_rst_frame", 32'(frame_count), 32'h0);
    vsync = 1'b1;
    tick;
    reset = 1'b0;
    tick; tick;
    frame;
    chk("t6_post_nd", 32'(nd_commit), 32'h0);
    chk("t6_post_location", 32'(location), 32'h0);
    chk("t6_post_frame", 32'(frame_count), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
